// File: rtl/swipt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : swipt_pkg                                                      |
// | Purpose : Shared types and constants for the SWIPT frequency controller: |
// |           controller state encoding, frequency word width, default/min/  |
// |           max frequency words and the PLL unlock status code.            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package swipt_pkg;

   localparam int FREQ_W = 32;

   localparam logic [FREQ_W-1:0] C_FREQ_DEFAULT = 32'h0000_9C40;
   localparam logic [FREQ_W-1:0] C_FREQ_MIN     = 32'h0000_9000;
   localparam logic [FREQ_W-1:0] C_FREQ_MAX     = 32'h0000_A800;
   localparam logic [FREQ_W-1:0] C_MAX_STEP     = 32'h0000_0040;

   // PLL status code meaning "not locked"; every other code is a valid sample
   localparam logic [1:0] PLL_ERR_UNLOCK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_TRACK  = 2'd2,
      ST_HOLD   = 2'd3
   } swipt_state_e;

   // Unsigned range clamp over full-width values
   function automatic logic [FREQ_W-1:0] clamp_freq(
      input logic [FREQ_W-1:0] f,
      input logic [FREQ_W-1:0] lo,
      input logic [FREQ_W-1:0] hi
   );
      if (f < lo)      return lo;
      else if (f > hi) return hi;
      else             return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/swipt_freq_avg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : swipt_freq_avg                                                 |
// | Purpose : Decimates the PLL frequency estimate and averages 2^AVG_LG     |
// |           valid samples into one frequency word.                         |
// | Ports   : clk, rst          clock / synchronous active-high reset        |
// |           i_run             decimation counter runs (else held at 0)     |
// |           i_accum           accumulate samples (else acc/count cleared)  |
// |           i_pll_freq        PLL frequency estimate                       |
// |           i_pll_error       PLL status (PLL_ERR_UNLOCK = unlocked)       |
// |           o_sample_stb      this cycle is a sample point                 |
// |           o_unlock          current PLL status is unlock                 |
// |           o_avg_valid/o_avg one-cycle strobe with the window average     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module swipt_freq_avg
   import swipt_pkg::*;
#(
   parameter int unsigned UPDATE_DIV = 16,
   parameter int unsigned AVG_LG     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_run,
   input  logic              i_accum,
   input  logic [FREQ_W-1:0] i_pll_freq,
   input  logic [1:0]        i_pll_error,
   output logic              o_sample_stb,
   output logic              o_unlock,
   output logic              o_avg_valid,
   output logic [FREQ_W-1:0] o_avg
);

   localparam int unsigned DEC_W = $clog2(UPDATE_DIV);
   localparam int unsigned ACC_W = FREQ_W + AVG_LG;
   localparam int unsigned NSAMP = 1 << AVG_LG;
   localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(UPDATE_DIV - 1);
   localparam logic [4:0]       SCNT_LAST = 5'(NSAMP - 1);

   logic [DEC_W-1:0]  r_dec;
   logic [ACC_W-1:0]  r_acc;
   logic [4:0]        r_scnt;
   logic              r_avg_valid;
   logic [FREQ_W-1:0] r_avg;

   logic              w_stb;
   logic              w_unlock;
   logic [ACC_W-1:0]  w_sum;

   assign w_stb    = i_run && (r_dec == DEC_LAST);
   assign w_unlock = (i_pll_error == PLL_ERR_UNLOCK);
   // At most 2^AVG_LG full-scale words are summed, so ACC_W never overflows
   assign w_sum    = r_acc + ACC_W'(i_pll_freq);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dec       <= '0;
         r_acc       <= '0;
         r_scnt      <= '0;
         r_avg_valid <= 1'b0;
         r_avg       <= '0;
      end else begin
         r_avg_valid <= 1'b0;

         if (!i_run || (r_dec == DEC_LAST)) begin
            r_dec <= '0;
         end else begin
            r_dec <= r_dec + DEC_W'(1);
         end

         if (!i_accum) begin
            r_acc  <= '0;
            r_scnt <= '0;
         end else if (w_stb) begin
            if (w_unlock) begin
               // Partial window is discarded on unlock
               r_acc  <= '0;
               r_scnt <= '0;
            end else if (r_scnt == SCNT_LAST) begin
               r_acc       <= '0;
               r_scnt      <= '0;
               r_avg_valid <= 1'b1;
               r_avg       <= FREQ_W'(w_sum >> AVG_LG);
            end else begin
               r_acc  <= w_sum;
               r_scnt <= r_scnt + 5'd1;
            end
         end
      end
   end

   assign o_sample_stb = w_stb;
   assign o_unlock     = w_unlock;
   assign o_avg_valid  = r_avg_valid;
   assign o_avg        = r_avg;

endmodule
`default_nettype wire

// File: rtl/swipt_freq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : swipt_freq_ctrl                                                |
// | Purpose : Frequency-word controller between the PLL and the SWIPT output |
// |           generator. Averages decimated PLL estimates, clamps them to    |
// |           [FREQ_MIN, FREQ_MAX], optionally slew-limits, and holds the    |
// |           last good word while the PLL reports unlock.                   |
// | Ports   : clk, rst     clock / synchronous active-high reset             |
// |           swiptAlive   link-alive flag; low forces IDLE                  |
// |           pll_freq     PLL frequency estimate                            |
// |           pll_error    PLL status, 2'b11 = unlock                        |
// |           freq         registered frequency word                         |
// |           load_freq    1 = consumers use the loaded default word         |
// |           locked       1 in TRACK after at least one update              |
// |           upd_pulse    one-cycle strobe on every update of freq          |
// | Config  : SWIPT_FREQ_SLEW_EN  limits each update to +/- MAX_STEP         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module swipt_freq_ctrl
   import swipt_pkg::*;
#(
   parameter int unsigned       UPDATE_DIV    = 16,
   parameter int unsigned       AVG_LG        = 2,
   parameter int unsigned       SETTLE_CYCLES = 1000,
   parameter logic [FREQ_W-1:0] FREQ_DEFAULT  = C_FREQ_DEFAULT,
   parameter logic [FREQ_W-1:0] FREQ_MIN      = C_FREQ_MIN,
   parameter logic [FREQ_W-1:0] FREQ_MAX      = C_FREQ_MAX,
   parameter logic [FREQ_W-1:0] MAX_STEP      = C_MAX_STEP,
   parameter int unsigned       HOLD_EXIT     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              swiptAlive,
   input  logic [FREQ_W-1:0] pll_freq,
   input  logic [1:0]        pll_error,
   output logic [FREQ_W-1:0] freq,
   output logic              load_freq,
   output logic              locked,
   output logic              upd_pulse
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned CLN_W = $clog2(HOLD_EXIT + 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CLN_W-1:0] CLN_LAST = CLN_W'(HOLD_EXIT - 1);

   swipt_state_e      r_state, w_state_nxt;
   logic [SET_W-1:0]  r_settle_cnt, w_settle_nxt;
   logic [CLN_W-1:0]  r_clean_cnt, w_clean_nxt;
   logic [FREQ_W-1:0] r_freq, w_freq_nxt;
   logic              r_load_freq, w_load_nxt;
   logic              r_locked, w_locked_nxt;
   logic              r_upd_pulse, w_upd_nxt;

   logic              w_run;
   logic              w_accum;
   logic              w_sample_stb;
   logic              w_unlock;
   logic              w_avg_valid;
   logic [FREQ_W-1:0] w_avg;
   logic [FREQ_W-1:0] w_clamped;
   logic [FREQ_W-1:0] w_new_freq;

   // Gating with swiptAlive clears the averager in the same cycle the link drops
   assign w_run   = swiptAlive && ((r_state == ST_TRACK) || (r_state == ST_HOLD));
   assign w_accum = swiptAlive && (r_state == ST_TRACK);

   swipt_freq_avg #(
      .UPDATE_DIV (UPDATE_DIV),
      .AVG_LG     (AVG_LG)
   ) u_avg (
      .clk          (clk),
      .rst          (rst),
      .i_run        (w_run),
      .i_accum      (w_accum),
      .i_pll_freq   (pll_freq),
      .i_pll_error  (pll_error),
      .o_sample_stb (w_sample_stb),
      .o_unlock     (w_unlock),
      .o_avg_valid  (w_avg_valid),
      .o_avg        (w_avg)
   );

   assign w_clamped = clamp_freq(w_avg, FREQ_MIN, FREQ_MAX);

`ifdef SWIPT_FREQ_SLEW_EN
   logic [FREQ_W-1:0] w_delta;

   always_comb begin
      w_delta    = '0;
      w_new_freq = r_freq;
      if (w_clamped > r_freq) begin
         w_delta    = w_clamped - r_freq;
         w_new_freq = r_freq + ((w_delta > MAX_STEP) ? MAX_STEP : w_delta);
      end else begin
         w_delta    = r_freq - w_clamped;
         w_new_freq = r_freq - ((w_delta > MAX_STEP) ? MAX_STEP : w_delta);
      end
   end
`else
   logic w_unused_max_step;

   assign w_new_freq        = w_clamped;
   assign w_unused_max_step = ^MAX_STEP;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_clean_cnt  <= '0;
         r_freq       <= FREQ_DEFAULT;
         r_load_freq  <= 1'b1;
         r_locked     <= 1'b0;
         r_upd_pulse  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_clean_cnt  <= w_clean_nxt;
         r_freq       <= w_freq_nxt;
         r_load_freq  <= w_load_nxt;
         r_locked     <= w_locked_nxt;
         r_upd_pulse  <= w_upd_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle_cnt;
      w_clean_nxt  = r_clean_cnt;
      w_freq_nxt   = r_freq;
      w_locked_nxt = r_locked;
      w_upd_nxt    = 1'b0;

      if (!swiptAlive) begin
         // Link loss overrides every other transition
         w_state_nxt  = ST_IDLE;
         w_settle_nxt = '0;
         w_clean_nxt  = '0;
         w_freq_nxt   = FREQ_DEFAULT;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_freq_nxt   = FREQ_DEFAULT;
               w_locked_nxt = 1'b0;
               w_settle_nxt = '0;
               w_state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SET_LAST) begin
                  w_settle_nxt = '0;
                  w_state_nxt  = ST_TRACK;
               end else begin
                  w_settle_nxt = r_settle_cnt + SET_W'(1);
               end
            end
            ST_TRACK: begin
               if (w_sample_stb && w_unlock) begin
                  w_state_nxt  = ST_HOLD;
                  w_locked_nxt = 1'b0;
                  w_clean_nxt  = '0;
               end else if (w_avg_valid) begin
                  w_freq_nxt   = w_new_freq;
                  w_locked_nxt = 1'b1;
                  w_upd_nxt    = 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_sample_stb) begin
                  if (w_unlock) begin
                     w_clean_nxt = '0;
                  end else if (r_clean_cnt == CLN_LAST) begin
                     w_clean_nxt = '0;
                     w_state_nxt = ST_TRACK;
                  end else begin
                     w_clean_nxt = r_clean_cnt + CLN_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end

      w_load_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_SETTLE);
   end

   assign freq      = r_freq;
   assign load_freq = r_load_freq;
   assign locked    = r_locked;
   assign upd_pulse = r_upd_pulse;

endmodule
`default_nettype wire

// File: doc/swipt_freq_ctrl.md
# swipt_freq_ctrl

Frequency-word controller between the PLL and the SWIPT output generator. It decimates and averages the PLL frequency estimate, then range-clamps and slew-limits it. The result drives the registered `freq` word and the `load_freq` select consumed by the SwiptOut / PLL pair. It holds the last good word when the PLL reports unlock, and reverts to the default frequency whenever the SWIPT link is not alive.

## Interface
- `UPDATE_DIV`, 16: clk cycles between PLL samples (≥2).
- `AVG_LG`, 2: log2 of samples averaged per update (0..4).
- `SETTLE_CYCLES`, 1000: cycles held at default after `swiptAlive` rises.
- `FREQ_DEFAULT`, 32'h9C40: reset and idle frequency word.
- `FREQ_MIN`, 32'h9000: lower clamp (unsigned).
- `FREQ_MAX`, 32'hA800: upper clamp (unsigned).
- `MAX_STEP`, 32'h40: maximum change per update (slew feature).
- `HOLD_EXIT`, 4: consecutive clean samples needed to leave HOLD.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `swiptAlive` in 1: heartbeat-derived link-alive flag.
- `pll_freq` in 32: PLL frequency estimate (PLL `phase` output).
- `pll_error` in 2: PLL status; 2'b11 = unlock, any other value = valid.
- `freq` out 32: registered frequency word to SwiptOut and PLL.
- `load_freq` out 1: 1 = PLL/SwiptOut use the loaded default; 0 = tracking.
- `locked` out 1: 1 while in TRACK after at least one update.
- `upd_pulse` out 1: one-cycle strobe when `freq` changes due to an update.

## Operation
- States: IDLE, SETTLE, TRACK, HOLD.
- IDLE: `freq`=FREQ_DEFAULT, `load_freq`=1, `locked`=0. Go to SETTLE when `swiptAlive`=1.
- SETTLE: counts SETTLE_CYCLES with `load_freq`=1, then enters TRACK with `load_freq`=0, then clears the decimation counter and accumulator.
- TRACK: the decimation counter runs 0..UPDATE_DIV-1. `pll_freq` is sampled when count = UPDATE_DIV-1.
  - Valid samples are added to a (32+AVG_LG)-bit accumulator.
  - After 2^AVG_LG samples: avg = acc >> AVG_LG (truncating). Then clamp to [FREQ_MIN, FREQ_MAX], then slew (see Configuration). The result is written to `freq`, and the accumulator and sample count are cleared.
- TRACK → HOLD when a sample has `pll_error`=2'b11.
  - The partial accumulation is discarded.
  - `freq` is frozen and `locked`=0.
- HOLD: keeps sampling at the decimation rate.
  - HOLD_EXIT consecutive samples with `pll_error`≠2'b11 → TRACK with a fresh accumulation.
  - Any unlock sample resets the clean count.
- `swiptAlive`=0 in any state → IDLE next cycle. The accumulator and counters are cleared and `freq` returns to FREQ_DEFAULT. This takes priority over all other transitions.
- `rst` has priority over everything and has the same effect as IDLE entry.
- Arithmetic is unsigned, with no wrap: the clamp compares full 32-bit values and the accumulator cannot overflow at the stated width.

## Timing
- Reset values: `freq`=FREQ_DEFAULT, `load_freq`=1, `locked`=0, `upd_pulse`=0, state IDLE.
- SETTLE→TRACK: `load_freq` falls exactly SETTLE_CYCLES cycles after the first SETTLE cycle.
- Update latency: `freq` and `upd_pulse` are valid one clk after the edge capturing the final sample of a window.
  - With the defaults, the first update occurs 64 cycles after TRACK entry plus 1.
- `locked` rises together with the first `upd_pulse` in TRACK.
- `upd_pulse` is asserted even if the new value equals the old one.
- An unlock sample on the final sample of a window goes to HOLD; no update occurs.

## Configuration
- `SWIPT_FREQ_SLEW_EN` defined: new `freq` = old `freq` ± min(|clamped − old|, MAX_STEP).
- Undefined: new `freq` = clamped avg directly, and MAX_STEP is unused.

## Structure
- Shared package `swipt_pkg`: state enum, `FREQ_W`=32, default/min/max frequency constants, and the `PLL_ERR_UNLOCK`=2'b11 encoding.
- One sub-module, `swipt_freq_avg`: decimation counter, accumulator, and sample counter. Its output is `avg_valid`/`avg`. The parent holds the FSM, clamp, slew, and output registers.

## Test plan
- `rst` held 3 cycles → `freq`=0x9C40, `load_freq`=1, `locked`=0, `upd_pulse`=0.
- `swiptAlive`↑ with `pll_freq`=0x9C80 and `pll_error`=0 → `load_freq` falls after 1000 cycles. 65 cycles later: `freq`=0x9C80, `upd_pulse` for 1 cycle, `locked`=1.
- `pll_freq` steps to 0xA000 in TRACK:
  - With slew enabled → `freq` rises 0x40 per update (0x9CC0, 0x9D00, …) until 0xA000.
  - With slew disabled → `freq` jumps to 0xA000.
- `pll_freq`=0xB000 (high) or 0x8000 (low) → `freq` settles at 0xA800 or 0x9000 respectively.
- One sample with `pll_error`=2'b11 → HOLD: `locked`=0 and `freq` frozen. After 4 clean samples: TRACK, and the next update restores `locked`=1.
  - Also cover one unlock sample after 2 clean samples: requires 4 more clean samples.
- `swiptAlive` drops mid-window → next cycle IDLE: `freq`=0x9C40 and `load_freq`=1. On re-assertion there is no stale accumulation: the first update equals the fresh average.
